// File: rtl/ant_vga_render_pkg.sv
// Shared constants and types for the ant-colony VGA renderer.
package ant_vga_render_pkg;

  // Tile type field of a tile-map word.
  typedef enum logic [2:0] {
    T_EMPTY  = 3'd0,
    T_AIR    = 3'd1,
    T_DIRT   = 3'd2,
    T_GROUND = 3'd3,
    T_QUEEN  = 3'd4,
    T_WALL   = 3'd5,
    T_ERROR  = 3'd6,
    T_TUNNEL = 3'd7
  } tile_type_e;

  // 640x480@60 timing; visible widths are module parameters, the rest is fixed.
  localparam int H_VIS_DEF = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VIS_DEF + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_VIS_DEF = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VIS_DEF + V_FP + V_SYNC + V_BP;  // 525

  localparam int TILES_PER_ROW = 40;

  // Tile word layout.
  localparam int BIT_ANT   = 4;
  localparam int BIT_SUGAR = 3;
  localparam int TYPE_MSB  = 2;
  localparam int TYPE_LSB  = 0;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 11;

  // Per-pixel control flags carried down the pipeline next to the tile data.
  typedef struct packed {
    logic blank;
    logic hsync;   // active low
    logic vsync;   // active low
    logic fstart;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_IDLE = '{blank: 1'b1, hsync: 1'b1, vsync: 1'b1, fstart: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters and stage-0 decode of sync, blank and frame start.
module vga_timing
  import ant_vga_render_pkg::*;
#(
  parameter int H_VIS = H_VIS_DEF,
  parameter int V_VIS = V_VIS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output pix_ctl_t         ctl_o
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  // Next counter values: h wraps every line, v advances on h wrap.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Counter registers, parked at (0,0) while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Stage-0 flag decode straight off the counters.
  always_comb begin
    ctl_o.blank  = (hcnt_q >= H_VIS_C) || (vcnt_q >= V_VIS_C);
    ctl_o.hsync  = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    ctl_o.vsync  = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
    ctl_o.fstart = (hcnt_q == '0) && (vcnt_q == '0);
  end

  assign hcount_o = hcnt_q;
  assign vcount_o = vcnt_q;

endmodule

// File: rtl/ant_vga_render.sv
// Tile-map VGA renderer: stage 0 address, stage 1 RAM read, stage 2 colour.
module ant_vga_render
  import ant_vga_render_pkg::*;
#(
  parameter int H_VIS      = H_VIS_DEF,
  parameter int V_VIS      = V_VIS_DEF,
  parameter int TILE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] tile_addr,
  input  logic [4:0]        tile_data,
  input  logic [8:0]        colTunnel,
  input  logic [8:0]        colAnt,
  input  logic [8:0]        colSugar,
  input  logic [8:0]        colGround,
  input  logic [8:0]        colError,
  input  logic [8:0]        colQueen,
  input  logic [8:0]        colAir,
  input  logic [8:0]        colAirSugar,
  input  logic [8:0]        colWall,
  output logic [8:0]        rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  logic [CNT_W-1:0] hcount, vcount;
  pix_ctl_t         ctl_s0;
  logic [CNT_W-1:0] tile_col, tile_row;

  vga_timing #(
    .H_VIS (H_VIS),
    .V_VIS (V_VIS)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .hcount_o (hcount),
    .vcount_o (vcount),
    .ctl_o    (ctl_s0)
  );

  // Stage 0: tile-map address; forced to 0 outside the visible area.
  assign tile_col = hcount >> TILE_SHIFT;
  assign tile_row = vcount >> TILE_SHIFT;
  assign tile_addr = ctl_s0.blank ? '0
                   : ADDR_W'(tile_row) * ADDR_W'(TILES_PER_ROW) + ADDR_W'(tile_col);

  // Flags ride two registers so they line up with the RAM latency plus colour stage.
  pix_ctl_t [2:1] ctl_pipe_q;

  // Control-flag shift register; reset leaves every stage idle/blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_pipe_q <= {CTL_IDLE, CTL_IDLE};
    end else begin
      ctl_pipe_q[1] <= ctl_s0;
      ctl_pipe_q[2] <= ctl_pipe_q[1];
    end
  end

  // Stage 2 colour select: blank, then ant, then sugar, then tile type.
  tile_type_e ttype;
  logic [8:0] rgb_d, rgb_q;

  assign ttype = tile_type_e'(tile_data[TYPE_MSB:TYPE_LSB]);

  always_comb begin
    rgb_d = '0;
    if (ctl_pipe_q[1].blank) begin
      rgb_d = '0;
    end else if (tile_data[BIT_ANT]) begin
      rgb_d = colAnt;
    end else if (tile_data[BIT_SUGAR]) begin
      rgb_d = (ttype == T_AIR) ? colAirSugar : colSugar;
    end else begin
      case (ttype)
        T_TUNNEL: rgb_d = colTunnel;
        T_DIRT,
        T_GROUND: rgb_d = colGround;
        T_QUEEN:  rgb_d = colQueen;
        T_AIR:    rgb_d = colAir;
        T_WALL:   rgb_d = colWall;
        T_ERROR:  rgb_d = colError;
        default:  rgb_d = '0;
      endcase
    end
  end

  // Colour register; palette is live-sampled here every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  assign rgb         = rgb_q;
  assign hsync       = ctl_pipe_q[2].hsync;
  assign vsync       = ctl_pipe_q[2].vsync;
  assign frame_start = ctl_pipe_q[2].fstart;

endmodule

// File: doc/ant_vga_render.md
ANT_VGA_RENDER -- requirements
Module: ant_vga_render

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter V_VIS, default 480, visible lines per frame.
REQ-003 Parameter TILE_SHIFT, default 4, log2 of the tile edge in pixels (16x16 tiles).
REQ-004 clk  input  1  pixel clock, 25 MHz nominal.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tile_addr  output  11  tile-map read address, row*40+col.
REQ-007 tile_data  input  5  tile word from synchronous RAM; bit4=ant, bit3=sugar, bits2:0=tile type.
REQ-008 colTunnel, colAnt, colSugar, colGround, colError, colQueen, colAir, colAirSugar, colWall  input  9 each  palette colours as {R[2:0],G[2:0],B[2:0]}.
REQ-009 rgb  output  9  pixel colour.
REQ-010 hsync, vsync  output  1 each  active-low sync.
REQ-011 frame_start  output  1  one-cycle pulse at pixel (0,0) of each frame.

Function
REQ-012 Tile type codes are fixed: empty=0, air=1, dirt=2, ground=3, queen=4, wall=5, errorblock=6, tunnel=7.
REQ-013 hcount counts 0..799 and wraps to 0; vcount increments when hcount wraps and counts 0..524, then wraps to 0.
REQ-014 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 Stage 0 drives tile_addr combinationally from the counters: (vcount>>TILE_SHIFT)*40 + (hcount>>TILE_SHIFT); it is 0 when blanked.
REQ-017 tile_data is valid one cycle after tile_addr (stage 1).
REQ-018 Stage 2 registers rgb from tile_data and the stage-1 blank flag, in this priority order:
- blank -> 0
- ant=1 -> colAnt
- sugar=1 with type air -> colAirSugar
- sugar=1 with any other type -> colSugar
- otherwise by type: tunnel->colTunnel; dirt and ground->colGround; queen->colQueen; air->colAir; wall->colWall; errorblock->colError; empty->0.
REQ-019 hsync, vsync and frame_start are decoded at stage 0 and delayed two registers, so all outputs for a given pixel appear together exactly 2 cycles after its counter value.
REQ-020 The palette inputs are sampled at stage 2 each cycle; a palette change takes effect on the next registered pixel.
REQ-021 frame_start is high for exactly one cycle per 420000-cycle frame.

Reset
REQ-022 While rst=0: hcount=0, vcount=0, rgb=0, hsync=1, vsync=1, frame_start=0, and all pipeline registers are cleared with the blank flag set.
REQ-023 Asserting rst mid-frame forces the REQ-022 values immediately, without waiting for a clock edge.
REQ-024 After rst is released, the first rising edge starts counting from (0,0); the first frame_start pulse appears 2 cycles after (0,0) is decoded at stage 0.

Structure
REQ-025 A shared package holds:
- tile type codes
- timing constants: H totals, porches and sync; V totals, porches and sync
- TILES_PER_ROW=40
- the tile-word bit positions.
REQ-026 One sub-module, vga_timing, holds the counters and the sync/blank/frame_start decode; the pipeline and colour mux stay in ant_vga_render.

Verification
REQ-027 Reset release, run one frame -> hsync low for 96 cycles per line starting at hcount 656+2 output cycles; vsync low for 2 lines; frame_start period is 420000 cycles.
REQ-028 Model RAM returns type=tunnel at every address, colTunnel=9'b111000000 -> rgb=9'b111000000 across all visible pixels and 0 during blanking.
REQ-029 Address check: at hcount=35, vcount=20 -> tile_addr=1*40+2=42; at hcount=639, vcount=479 -> tile_addr=1199.
REQ-030 Word 5'b01001 (sugar, air) -> colAirSugar; 5'b01111 -> colSugar; 5'b11111 -> colAnt; 5'b00000 -> 0.
REQ-031 Assert rst=0 at hcount=300, vcount=200 -> outputs take their reset values without a clock edge; after release, counting restarts at (0,0).
REQ-032 Change colWall from 9'b110000000 to 9'b000000111 on a wall tile -> rgb changes on the next clock edge.
